data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-addressed 64-bit data memory for the single-cycle processor's memory stage.
- Writes are synchronous; reads are combinational, so load data is available in the same cycle the address is presented.
- Each Address value selects one independent 64-bit entry. Entries never overlap; there is no byte addressing, alignment or endianness logic.

Parameters:
- DATA_WIDTH, 64, width of each entry, WriteData and ReadData.
- ADDR_BITS, 6, number of low Address bits used as the entry index.
- DEPTH, 2**ADDR_BITS (64), number of entries.

Ports:
- Clock  in  1  system clock; all writes occur on its rising edge.
- ResetL  in  1  asynchronous active-low reset.
- Address  in  64  entry index; only Address[ADDR_BITS-1:0] is used, upper bits are ignored.
- WriteData  in  DATA_WIDTH  data to store.
- MemoryRead  in  1  read enable.
- MemoryWrite  in  1  write enable.
- ReadData  out  DATA_WIDTH  read result.

Behaviour:
- Reset: ResetL low clears every entry to 0 immediately, independent of Clock. While ResetL is low, writes are ignored. ReadData follows from the cleared array: 0 when MemoryRead=1, otherwise 0 by the idle rule below.
- Index: idx = Address[ADDR_BITS-1:0]. Addresses differing only above bit ADDR_BITS-1 alias to the same entry. This is not an error and is not flagged.
- Write: on a rising Clock edge with ResetL high and MemoryWrite=1, mem[idx] <= WriteData. The new value is visible on ReadData immediately after that edge.
- Read: ReadData = mem[idx] combinationally when MemoryRead=1, with zero-cycle latency. When MemoryRead=0, ReadData = 0.
- Read and write to the same idx in the same cycle: before the edge ReadData shows the old contents; after the edge it shows WriteData. There is no write-through bypass.
- MemoryRead and MemoryWrite both 1: both take effect as described above; there is no priority conflict.
- Repeated writes to the same idx: the last write wins.
- Neighbouring indices (for example 0x32 and 0x33) are fully independent.
- No handshake and no busy state; every access completes in one cycle.

Decomposition:
- Shared package: DATA_WIDTH (64) and the memory-op enable encoding shared with control.
- No sub-module. The design is a single register-array module with one write process (asynchronous clear) and one combinational read mux.

Test Plan:
- Reset test: pulse ResetL low, then MemoryRead=1 at Address 0x14 -> ReadData=0.
- Initialise: write 0x0=4, 0x4=3, 0x8=50, 0xc=40, 0x10=30, 0x14=0, 0x20=0, 0x1e=0x132, 0x20=16435934, 0x32=0xaaaaffff, 0x33=1431699200, 0x3c=0xffff0000, then assert reads:
  - 0x14 -> 0
  - 0x3c -> 0xffff0000
  - 0x33 -> 1431699200
  - 0x32 -> 0xaaaaffff (neighbour unaffected)
  - 0xc -> 40
- Overwrite: 0x20 read after the second write -> 16435934.
- Same-cycle read/write: Address=0x8, MemoryRead=1, MemoryWrite=1, WriteData=0x77 -> ReadData=50 before the edge, 0x77 after it.
- Idle and alias:
  - MemoryRead=0 -> ReadData=0.
  - Address 0x40+0xc (upper bits set) with MemoryRead=1 -> 40.
- Write disabled: MemoryWrite=0 with WriteData=0xdead at 0x4 over several edges -> read 0x4 remains 3.

Source files
------------

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: widths and the memory-op encoding shared between control and the data memory.
package data_memory_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 64;
  localparam int ADDR_BITS  = 6;
  localparam int DEPTH      = 2 ** ADDR_BITS;
  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_RW    = 2'b11
  } mem_op_e;
endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: memory-stage bus between the datapath (master) and the data memory (slave).
interface data_memory_if;
  import data_memory_pkg::*;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemoryRead;
  logic                  MemoryWrite;
  logic [DATA_WIDTH-1:0] ReadData;
  modport master (output Address, WriteData, MemoryRead, MemoryWrite, input ReadData);
  modport slave  (input Address, WriteData, MemoryRead, MemoryWrite, output ReadData);
endinterface

// File: rtl/data_memory.sv
// data_memory: word-addressed 64-bit register array; clocked writes, combinational reads,
// asynchronous clear. Upper address bits alias onto the low ADDR_BITS index.
module data_memory
  import data_memory_pkg::*;
(
  input logic          i_Clock,
  input logic          i_ResetL,
  data_memory_if.slave bus
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_BITS-1:0]  w_idx;
  mem_op_e               w_op;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_unused;
  always_comb begin
    w_idx        = bus.Address[ADDR_BITS-1:0];
    w_op         = mem_op_e'({bus.MemoryWrite, bus.MemoryRead});
    w_rd         = (w_op == MEM_READ) || (w_op == MEM_RW);
    w_wr         = (w_op == MEM_WRITE) || (w_op == MEM_RW);
    bus.ReadData = w_rd ? r_mem[w_idx] : '0;
  end
  assign w_unused = ^bus.Address[ADDR_WIDTH-1:ADDR_BITS];
  always_ff @(posedge i_Clock or negedge i_ResetL)
    if (!i_ResetL) r_mem <= '{default: '0};
    else if (w_wr) r_mem[w_idx] <= bus.WriteData;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed vectors; stimulus pushes expected ReadData into a scoreboard queue,
// a negedge monitor pops and compares whenever a check is requested.
module tb_data_memory;
  import data_memory_pkg::*;
  typedef struct {
    string                 name;
    logic [DATA_WIDTH-1:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk = 1'b0;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  data_memory_if bus();
  data_memory dut (.i_Clock(clk), .i_ResetL(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (chk) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got %h, no expected value queued", bus.ReadData);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.ReadData !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", e.name, bus.ReadData, e.v);
        end
      end
    end
  task automatic idle();
    bus.MemoryRead = 1'b0;
    bus.MemoryWrite = 1'b0;
    chk = 1'b0;
  endtask
  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    bus.Address = a;
    bus.WriteData = d;
    bus.MemoryWrite = 1'b1;
    bus.MemoryRead = 1'b0;
    @(posedge clk); #1;
    idle();
  endtask
  task automatic rd(input string n, input logic [63:0] a, input logic [63:0] e);
    bus.Address = a;
    bus.MemoryRead = 1'b1;
    bus.MemoryWrite = 1'b0;
    sb.push_back('{n, e});
    chk = 1'b1;
    @(posedge clk); #1;
    idle();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.Address = '0;
    bus.WriteData = '0;
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wr(64'h14, 64'h5);
    wr(64'h3c, 64'h1234);
    rd("pre_reset_0x14", 64'h14, 64'h5);
    rst_n = 1'b0;
    rd("async_clear_0x14", 64'h14, 64'h0);
    bus.Address = 64'h3c;
    bus.WriteData = 64'h99;
    bus.MemoryWrite = 1'b1;
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    rd("write_during_reset_0x3c", 64'h3c, 64'h0);
    rd("reset_0x14", 64'h14, 64'h0);
    wr(64'h0, 64'd4);
    wr(64'h4, 64'd3);
    wr(64'h8, 64'd50);
    wr(64'hc, 64'd40);
    wr(64'h10, 64'd30);
    wr(64'h14, 64'd0);
    wr(64'h20, 64'd0);
    wr(64'h1e, 64'h132);
    wr(64'h20, 64'd16435934);
    wr(64'h32, 64'haaaaffff);
    wr(64'h33, 64'd1431699200);
    wr(64'h3c, 64'hffff0000);
    rd("init_0x14", 64'h14, 64'd0);
    rd("init_0x3c", 64'h3c, 64'hffff0000);
    rd("init_0x33", 64'h33, 64'd1431699200);
    rd("neighbour_0x32", 64'h32, 64'haaaaffff);
    rd("init_0xc", 64'hc, 64'd40);
    rd("init_0x0", 64'h0, 64'd4);
    rd("init_0x1e", 64'h1e, 64'h132);
    rd("init_0x10", 64'h10, 64'd30);
    rd("overwrite_0x20", 64'h20, 64'd16435934);
    bus.Address = 64'h8;
    bus.WriteData = 64'h77;
    bus.MemoryRead = 1'b1;
    bus.MemoryWrite = 1'b1;
    sb.push_back('{"rw_before_edge", 64'd50});
    chk = 1'b1;
    @(posedge clk); #1;
    bus.MemoryWrite = 1'b0;
    sb.push_back('{"rw_after_edge", 64'h77});
    @(posedge clk); #1;
    idle();
    bus.Address = 64'h8;
    sb.push_back('{"idle_read_zero", 64'h0});
    chk = 1'b1;
    @(posedge clk); #1;
    idle();
    rd("alias_0x4c", 64'h4c, 64'd40);
    rd("alias_high_bits", 64'hffff_0000_0000_000c, 64'd40);
    wr(64'h41, 64'hdeadbeef_cafef00d);
    rd("alias_write_0x1", 64'h1, 64'hdeadbeef_cafef00d);
    rd("alias_no_spill_0x0", 64'h0, 64'd4);
    wr(64'h3f, 64'h8000_0000_0000_0001);
    rd("full_width_0x3f", 64'h3f, 64'h8000_0000_0000_0001);
    rd("last_entry_neighbour_0x3e", 64'h3e, 64'h0);
    bus.Address = 64'h4;
    bus.WriteData = 64'hdead;
    repeat (3) @(posedge clk);
    #1;
    rd("write_disabled_0x4", 64'h4, 64'd3);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    rd("second_reset_0x3c", 64'h3c, 64'h0);
    rd("second_reset_0x1", 64'h1, 64'h0);
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
